// File: rtl/ipic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ipic_arbiter
//  Description : Round-robin arbiter between two requesters and IPIC
//                transaction sequencer. Rejects unmapped addresses and kills
//                accesses that stall past C_TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ipic_arbiter #(
  parameter int C_TIMEOUT = 64
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_resetn,
  // requester 0 (host register bridge)
  input  logic        req0_valid,
  input  logic        req0_rnw,
  input  logic [11:0] req0_addr,
  input  logic [31:0] req0_wrdata,
  output logic        req0_done,
  output logic        req0_error,
  output logic [31:0] req0_rddata,
  // requester 1 (configuration loader)
  input  logic        req1_valid,
  input  logic        req1_rnw,
  input  logic [11:0] req1_addr,
  input  logic [31:0] req1_wrdata,
  output logic        req1_done,
  output logic        req1_error,
  output logic [31:0] req1_rddata,
  // IPIC master port
  output logic        bus2ip_cs,
  output logic        bus2ip_rdce,
  output logic        bus2ip_wrce,
  output logic [11:0] bus2ip_addr,
  output logic [31:0] bus2ip_data,
  input  logic        ip2bus_rdack,
  input  logic        ip2bus_wrack,
  input  logic        ip2bus_error,
  input  logic [31:0] ip2bus_data,
  // status
  output logic        arb_busy,
  output logic        arb_timeout
);

  localparam int            CW        = $clog2(C_TIMEOUT);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(C_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;     // requester granted most recently
  logic          r_gnt;      // requester owning the current access
  logic          r_rnw;
  logic [CW-1:0] r_cnt;
  logic          r_cs;
  logic          r_rdce;
  logic          r_wrce;
  logic [11:0]   r_addr;
  logic [31:0]   r_data;
  logic [1:0]    r_done;
  logic [1:0]    r_error;
  logic [31:0]   r_rddata [2];
  logic          r_busy;
  logic          r_timeout;

  logic          w_any;
  logic          w_gnt;
  logic          w_rnw;
  logic [11:0]   w_addr;
  logic [31:0]   w_wrdata;
  logic          w_mapped;
  logic          w_ack;
  logic          w_expired;
  logic          w_term;

  // Grant selection and termination decode for the current cycle
  always_comb begin
    w_any     = req0_valid | req1_valid;
    w_gnt     = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt = ~r_last;
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end
    w_rnw     = w_gnt ? req1_rnw    : req0_rnw;
    w_addr    = w_gnt ? req1_addr   : req0_addr;
    w_wrdata  = w_gnt ? req1_wrdata : req0_wrdata;
    // Only 0x200..0x7FF decodes to an IPIC register region
    w_mapped  = ~w_addr[11] & (w_addr[10:9] != 2'b00);
    // An ack of the wrong type does not count
    w_ack     = r_rnw ? ip2bus_rdack : ip2bus_wrack;
    w_expired = (r_cnt == C_CNT_MAX);
    w_term    = w_ack | ip2bus_error | w_expired;
  end

  // Arbitration / access sequencing FSM with registered outputs
  always_ff @(posedge bus2ip_clk) begin
    if (!bus2ip_resetn) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_gnt       <= 1'b0;
      r_rnw       <= 1'b0;
      r_cnt       <= '0;
      r_cs        <= 1'b0;
      r_rdce      <= 1'b0;
      r_wrce      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 2'b00;
      r_error     <= 2'b00;
      r_rddata[0] <= '0;
      r_rddata[1] <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done    <= 2'b00;
      r_error   <= 2'b00;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last <= w_gnt;
            r_gnt  <= w_gnt;
            r_busy <= 1'b1;
            if (w_mapped) begin
              r_addr  <= w_addr;
              r_data  <= w_wrdata;
              r_rnw   <= w_rnw;
              r_cs    <= 1'b1;
              r_rdce  <= w_rnw;
              r_wrce  <= ~w_rnw;
              r_cnt   <= '0;
              r_state <= S_ACCESS;
            end else begin
              // Unmapped: fail immediately without touching the bus
              r_done[w_gnt]  <= 1'b1;
              r_error[w_gnt] <= 1'b1;
              r_state        <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          if (w_term) begin
            r_cs           <= 1'b0;
            r_rdce         <= 1'b0;
            r_wrce         <= 1'b0;
            r_done[r_gnt]  <= 1'b1;
            // A matching ack reports the mux's error flag; any other
            // termination (bare error or expiry) is a failure
            r_error[r_gnt] <= w_ack ? ip2bus_error : 1'b1;
            r_timeout      <= ~w_ack & ~ip2bus_error;
            if (r_rnw && ip2bus_rdack) begin
              r_rddata[r_gnt] <= ip2bus_data;
            end
            r_state        <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus2ip_cs   = r_cs;
  assign bus2ip_rdce = r_rdce;
  assign bus2ip_wrce = r_wrce;
  assign bus2ip_addr = r_addr;
  assign bus2ip_data = r_data;
  assign req0_done   = r_done[0];
  assign req1_done   = r_done[1];
  assign req0_error  = r_error[0];
  assign req1_error  = r_error[1];
  assign req0_rddata = r_rddata[0];
  assign req1_rddata = r_rddata[1];
  assign arb_busy    = r_busy;
  assign arb_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ipic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipic_arbiter
//  Description : Directed self-checking bench for ipic_arbiter (C_TIMEOUT=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ipic_arbiter;

  logic        bus2ip_clk = 1'b0;
  logic        bus2ip_resetn = 1'b0;
  logic        req0_valid = 1'b0, req0_rnw = 1'b0;
  logic [11:0] req0_addr = '0;
  logic [31:0] req0_wrdata = '0;
  logic        req0_done, req0_error;
  logic [31:0] req0_rddata;
  logic        req1_valid = 1'b0, req1_rnw = 1'b0;
  logic [11:0] req1_addr = '0;
  logic [31:0] req1_wrdata = '0;
  logic        req1_done, req1_error;
  logic [31:0] req1_rddata;
  logic        bus2ip_cs, bus2ip_rdce, bus2ip_wrce;
  logic [11:0] bus2ip_addr;
  logic [31:0] bus2ip_data;
  logic        ip2bus_rdack = 1'b0, ip2bus_wrack = 1'b0, ip2bus_error = 1'b0;
  logic [31:0] ip2bus_data = '0;
  logic        arb_busy, arb_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  ipic_arbiter #(.C_TIMEOUT(8)) dut (
    .bus2ip_clk(bus2ip_clk), .bus2ip_resetn(bus2ip_resetn),
    .req0_valid(req0_valid), .req0_rnw(req0_rnw), .req0_addr(req0_addr),
    .req0_wrdata(req0_wrdata), .req0_done(req0_done), .req0_error(req0_error),
    .req0_rddata(req0_rddata),
    .req1_valid(req1_valid), .req1_rnw(req1_rnw), .req1_addr(req1_addr),
    .req1_wrdata(req1_wrdata), .req1_done(req1_done), .req1_error(req1_error),
    .req1_rddata(req1_rddata),
    .bus2ip_cs(bus2ip_cs), .bus2ip_rdce(bus2ip_rdce), .bus2ip_wrce(bus2ip_wrce),
    .bus2ip_addr(bus2ip_addr), .bus2ip_data(bus2ip_data),
    .ip2bus_rdack(ip2bus_rdack), .ip2bus_wrack(ip2bus_wrack),
    .ip2bus_error(ip2bus_error), .ip2bus_data(ip2bus_data),
    .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );

  always #5 bus2ip_clk = ~bus2ip_clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge bus2ip_clk);
    #1;
  endtask

  task automatic test_reset();
    bus2ip_resetn = 1'b0;
    tick(); tick();
    n_tests++; if ({bus2ip_cs, bus2ip_rdce, bus2ip_wrce} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {bus2ip_cs, bus2ip_rdce, bus2ip_wrce}); end
    n_tests++; if ({bus2ip_addr, bus2ip_data} !== 44'd0) begin n_fail++; $display("FAIL rst_bus: got addr %h data %h want 0", bus2ip_addr, bus2ip_data); end
    n_tests++; if ({req0_done, req0_error, req1_done, req1_error, arb_busy, arb_timeout} !== 6'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 000000", {req0_done, req0_error, req1_done, req1_error, arb_busy, arb_timeout}); end
    n_tests++; if ({req0_rddata, req1_rddata} !== 64'd0) begin n_fail++; $display("FAIL rst_rddata: got %h %h want 0", req0_rddata, req1_rddata); end
  endtask

  // Contention three times in a row with both valids held high
  task automatic test_round_robin();
    int          exp_g [3] = '{0, 1, 0};
    logic [11:0] want_a;
    logic [31:0] want_d;
    req0_rnw = 1'b0; req0_addr = 12'h600; req0_wrdata = 32'hAAAA0000;
    req1_rnw = 1'b0; req1_addr = 12'h20C; req1_wrdata = 32'hBBBB1111;
    req0_valid = 1'b1; req1_valid = 1'b1;
    bus2ip_resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want_a = (exp_g[i] == 1) ? 12'h20C : 12'h600;
      want_d = (exp_g[i] == 1) ? 32'hBBBB1111 : 32'hAAAA0000;
      tick();
      n_tests++; if ({bus2ip_cs, bus2ip_rdce, bus2ip_wrce} !== 3'b101) begin n_fail++; $display("FAIL rr_launch%0d: got %b want 101", i, {bus2ip_cs, bus2ip_rdce, bus2ip_wrce}); end
      n_tests++; if (bus2ip_addr !== want_a || bus2ip_data !== want_d) begin n_fail++; $display("FAIL rr_grant%0d: got %h/%h want %h/%h", i, bus2ip_addr, bus2ip_data, want_a, want_d); end
      ip2bus_wrack = 1'b1;
      tick();
      ip2bus_wrack = 1'b0;
      n_tests++; if ({req0_done, req1_done} !== ((exp_g[i] == 1) ? 2'b01 : 2'b10) || bus2ip_cs !== 1'b0) begin n_fail++; $display("FAIL rr_done%0d: got done0/1 %b cs %b want grant %0d cs 0", i, {req0_done, req1_done}, bus2ip_cs, exp_g[i]); end
      tick();
      n_tests++; if (bus2ip_cs !== 1'b0 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d: got cs %b busy %b want 0 0", i, bus2ip_cs, arb_busy); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_read();
    req0_rnw = 1'b1; req0_addr = 12'h404; req0_valid = 1'b1;
    tick();
    n_tests++; if ({bus2ip_cs, bus2ip_rdce, bus2ip_wrce} !== 3'b110 || bus2ip_addr !== 12'h404 || arb_busy !== 1'b1) begin n_fail++; $display("FAIL rd_launch: got %b addr %h busy %b want 110 404 1", {bus2ip_cs, bus2ip_rdce, bus2ip_wrce}, bus2ip_addr, arb_busy); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_tests++; if (bus2ip_cs !== 1'b1 || req0_done !== 1'b0) begin n_fail++; $display("FAIL rd_hold%0d: got cs %b done %b want 1 0", c, bus2ip_cs, req0_done); end
    end
    ip2bus_rdack = 1'b1; ip2bus_data = 32'hCAFE0001;
    tick();
    ip2bus_rdack = 1'b0; ip2bus_data = '0;
    n_tests++; if (req0_done !== 1'b1 || req0_error !== 1'b0 || req0_rddata !== 32'hCAFE0001 || bus2ip_cs !== 1'b0) begin n_fail++; $display("FAIL rd_done: got done %b err %b data %h cs %b want 1 0 cafe0001 0", req0_done, req0_error, req0_rddata, bus2ip_cs); end
    req0_valid = 1'b0;
    tick();
    n_tests++; if (req0_done !== 1'b0 || req0_rddata !== 32'hCAFE0001 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL rd_after: got done %b data %h busy %b want 0 cafe0001 0", req0_done, req0_rddata, arb_busy); end
  endtask

  task automatic test_unmapped();
    req1_rnw = 1'b0; req1_addr = 12'h100; req1_wrdata = 32'h0BAD0BAD; req1_valid = 1'b1;
    tick();
    n_tests++; if (bus2ip_cs !== 1'b0 || req1_done !== 1'b1 || req1_error !== 1'b1 || req0_done !== 1'b0) begin n_fail++; $display("FAIL um_done: got cs %b done1 %b err1 %b done0 %b want 0 1 1 0", bus2ip_cs, req1_done, req1_error, req0_done); end
    n_tests++; if (req1_rddata !== 32'd0) begin n_fail++; $display("FAIL um_rddata: got %h want 0", req1_rddata); end
    req1_valid = 1'b0;
    tick();
    n_tests++; if (bus2ip_cs !== 1'b0 || req1_done !== 1'b0 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL um_after: got cs %b done %b busy %b want 0 0 0", bus2ip_cs, req1_done, arb_busy); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    req0_rnw = 1'b1; req0_addr = 12'h204; req0_valid = 1'b1;
    tick();
    while (bus2ip_cs === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL to_cs_len: got %0d cycles want 8", cnt); end
    n_tests++; if (req0_done !== 1'b1 || req0_error !== 1'b1 || arb_timeout !== 1'b1) begin n_fail++; $display("FAIL to_done: got done %b err %b to %b want 1 1 1", req0_done, req0_error, arb_timeout); end
    n_tests++; if (req0_rddata !== 32'hCAFE0001) begin n_fail++; $display("FAIL to_rddata: got %h want cafe0001", req0_rddata); end
    req0_valid = 1'b0;
    tick();
    tick();
    ip2bus_rdack = 1'b1; ip2bus_data = 32'hDEADBEEF;
    tick();
    ip2bus_rdack = 1'b0; ip2bus_data = '0;
    n_tests++; if (req0_done !== 1'b0 || req0_rddata !== 32'hCAFE0001 || bus2ip_cs !== 1'b0 || arb_timeout !== 1'b0) begin n_fail++; $display("FAIL to_stray: got done %b data %h cs %b to %b want 0 cafe0001 0 0", req0_done, req0_rddata, bus2ip_cs, arb_timeout); end
  endtask

  task automatic test_write_error();
    req1_rnw = 1'b0; req1_addr = 12'h608; req1_wrdata = 32'h12345678; req1_valid = 1'b1;
    tick();
    n_tests++; if ({bus2ip_cs, bus2ip_rdce, bus2ip_wrce} !== 3'b101 || bus2ip_data !== 32'h12345678) begin n_fail++; $display("FAIL we_launch: got %b data %h want 101 12345678", {bus2ip_cs, bus2ip_rdce, bus2ip_wrce}, bus2ip_data); end
    ip2bus_wrack = 1'b1; ip2bus_error = 1'b1;
    tick();
    ip2bus_wrack = 1'b0; ip2bus_error = 1'b0;
    n_tests++; if (req1_done !== 1'b1 || req1_error !== 1'b1 || arb_timeout !== 1'b0) begin n_fail++; $display("FAIL we_done: got done %b err %b to %b want 1 1 0", req1_done, req1_error, arb_timeout); end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrong_ack();
    req1_rnw = 1'b1; req1_addr = 12'h40C; req1_valid = 1'b1;
    tick();
    ip2bus_wrack = 1'b1;
    tick();
    ip2bus_wrack = 1'b0;
    n_tests++; if (bus2ip_cs !== 1'b1 || req1_done !== 1'b0) begin n_fail++; $display("FAIL wa_ignored: got cs %b done %b want 1 0", bus2ip_cs, req1_done); end
    tick();
    ip2bus_rdack = 1'b1; ip2bus_data = 32'h5A5A5A5A;
    tick();
    ip2bus_rdack = 1'b0; ip2bus_data = '0;
    n_tests++; if (req1_done !== 1'b1 || req1_error !== 1'b0 || req1_rddata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL wa_done: got done %b err %b data %h want 1 0 5a5a5a5a", req1_done, req1_error, req1_rddata); end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req1_rnw = 1'b0; req1_addr = 12'h600; req1_wrdata = 32'h0F0F0F0F; req1_valid = 1'b1;
    tick();
    tick();
    n_tests++; if (bus2ip_cs !== 1'b1) begin n_fail++; $display("FAIL rm_active: got cs %b want 1", bus2ip_cs); end
    bus2ip_resetn = 1'b0;
    tick();
    n_tests++; if ({bus2ip_cs, bus2ip_rdce, bus2ip_wrce} !== 3'b000 || req1_done !== 1'b0 || req0_done !== 1'b0 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL rm_abort: got %b done1 %b done0 %b busy %b want 000 0 0 0", {bus2ip_cs, bus2ip_rdce, bus2ip_wrce}, req1_done, req0_done, arb_busy); end
    bus2ip_resetn = 1'b1;
    req0_rnw = 1'b1; req0_addr = 12'h404; req0_valid = 1'b1;
    tick();
    n_tests++; if (bus2ip_cs !== 1'b1 || bus2ip_rdce !== 1'b1 || bus2ip_addr !== 12'h404 || req1_done !== 1'b0) begin n_fail++; $display("FAIL rm_grant: got cs %b rdce %b addr %h done1 %b want 1 1 404 0", bus2ip_cs, bus2ip_rdce, bus2ip_addr, req1_done); end
    ip2bus_rdack = 1'b1; ip2bus_data = 32'h00000077;
    tick();
    ip2bus_rdack = 1'b0;
    n_tests++; if (req0_done !== 1'b1 || req0_rddata !== 32'h00000077 || req1_done !== 1'b0) begin n_fail++; $display("FAIL rm_done: got done0 %b data %h done1 %b want 1 00000077 0", req0_done, req0_rddata, req1_done); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_unmapped();
    test_timeout();
    test_write_error();
    test_wrong_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
